// File: rtl/u_rec_if.sv
// Host-side handshake bundle for the oversampled UART receiver.
// Received byte, valid/ack handshake, error pulses and busy status.
interface u_rec_if;
    logic [7:0] rec_dataH;
    logic       rec_validH;
    logic       rec_ackH;
    logic       frame_errH;
    logic       overrun_errH;
    logic       rec_busyH;

    modport master (
        output rec_dataH,
        output rec_validH,
        output frame_errH,
        output overrun_errH,
        output rec_busyH,
        input  rec_ackH
    );

    modport slave (
        input  rec_dataH,
        input  rec_validH,
        input  frame_errH,
        input  overrun_errH,
        input  rec_busyH,
        output rec_ackH
    );
endinterface

// File: rtl/u_rec.sv
// 16x-oversampled 8N1 UART receiver with start-glitch rejection and break handling.
// Latency: byte visible 153 cycles after the synchronized start edge (2-flop sync ahead of that).
// No backpressure: an unread byte is overwritten and overrun_errH pulses instead.
module u_rec (
    input  logic    sys_clk,
    input  logic    sys_rst,
    input  logic    uart_dataH,
    u_rec_if.master recIf
);

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_START = 3'd1,
        R_DATA  = 3'd2,
        R_STOP  = 3'd3,
        R_BREAK = 3'd4
    } rstate_t;

    rstate_t    state;
    logic       syncMeta;
    logic       sync;
    logic [3:0] cnt;
    logic [3:0] bits;
    logic [7:0] sr;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state               <= R_IDLE;
            syncMeta            <= 1'b1;
            sync                <= 1'b1;
            cnt                 <= 4'd0;
            bits                <= 4'd0;
            sr                  <= 8'h00;
            recIf.rec_dataH     <= 8'h00;
            recIf.rec_validH    <= 1'b0;
            recIf.frame_errH    <= 1'b0;
            recIf.overrun_errH  <= 1'b0;
            recIf.rec_busyH     <= 1'b0;
        end else begin
            syncMeta            <= uart_dataH;
            sync                <= syncMeta;
            recIf.frame_errH    <= 1'b0;
            recIf.overrun_errH  <= 1'b0;
            cnt                 <= cnt + 4'd1;
            if (recIf.rec_ackH) begin
                recIf.rec_validH <= 1'b0;
            end

            // rec_busyH is updated alongside every transition so it tracks the state exactly
            case (state)
                R_IDLE: begin
                    cnt <= 4'd0;
                    if (!sync) begin
                        state           <= R_START;
                        recIf.rec_busyH <= 1'b1;
                    end
                end
                R_START: begin
                    if (cnt == 4'd7) begin
                        cnt <= 4'd0;
                        if (!sync) begin
                            state <= R_DATA;
                            bits  <= 4'd0;
                        end else begin
                            state           <= R_IDLE;
                            recIf.rec_busyH <= 1'b0;
                        end
                    end
                end
                R_DATA: begin
                    if (cnt == 4'd15) begin
                        sr   <= {sync, sr[7:1]};
                        bits <= bits + 4'd1;
                        cnt  <= 4'd0;
                        if (bits == 4'd7) begin
                            state <= R_STOP;
                        end
                    end
                end
                R_STOP: begin
                    if (cnt == 4'd15) begin
                        cnt <= 4'd0;
                        if (sync) begin
                            recIf.rec_dataH    <= sr;
                            recIf.rec_validH   <= 1'b1;
                            // an ack in this same cycle consumes the old byte, so no overrun
                            recIf.overrun_errH <= recIf.rec_validH & ~recIf.rec_ackH;
                            state              <= R_IDLE;
                            recIf.rec_busyH    <= 1'b0;
                        end else begin
                            recIf.frame_errH <= 1'b1;
                            state            <= R_BREAK;
                        end
                    end
                end
                R_BREAK: begin
                    if (sync) begin
                        cnt             <= 4'd0;
                        state           <= R_IDLE;
                        recIf.rec_busyH <= 1'b0;
                    end
                end
                default: begin
                    cnt             <= 4'd0;
                    state           <= R_IDLE;
                    recIf.rec_busyH <= 1'b0;
                end
            endcase
        end
    end

endmodule
